// File: rtl/vscale_hasti_dp_sram_if.sv
// One AHB-Lite (hasti) slave port of the shared instruction/data SRAM.
// The master side drives the address/control and write data, and the
// slave side returns read data, ready and response.
interface vscale_hasti_dp_sram_if;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  modport master (
    output haddr, hwrite, hsize, htrans, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  haddr, hwrite, hsize, htrans, hwdata,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/vscale_hasti_dp_sram.sv
// Unified imem/dmem SRAM with two AHB-Lite slave ports (p0 = imem, p1 = dmem)
// sharing one word array. One array access happens per cycle. The port that
// loses arbitration has its data phase stretched with hready low. Illegal
// accesses (out of range, misaligned, bad size) never reach the array and
// answer with the two-cycle AHB ERROR response.
module vscale_hasti_dp_sram #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0,
  parameter int ARB_MODE    = 0
) (
  input logic                   clk,
  input logic                   reset,
  vscale_hasti_dp_sram_if.slave p0,
  vscale_hasti_dp_sram_if.slave p1
);

  localparam int              AW        = $clog2(DEPTH);
  localparam int              CW        = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CW-1:0]   WAIT_LAST = CW'(WAIT_STATES);
  localparam logic [31:0]     DEPTH_W   = 32'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_e;

  // Per-port views of the two buses, so both ports share one description.
  logic [31:0]   haddr_s  [2];
  logic          hwrite_s [2];
  logic [2:0]    hsize_s  [2];
  logic [1:0]    htrans_s [2];
  logic [31:0]   hwdata_s [2];
  logic [31:0]   hrdata_s [2];
  logic          hready_s [2];
  logic          hresp_s  [2];

  // Captured address phase and per-port transfer state.
  state_e        state_q  [2];
  logic [AW+1:0] addr_q   [2];
  logic          write_q  [2];
  logic [2:0]    size_q   [2];

  // Arbitration: a held grant survives wait states until completion.
  logic          gnt_hold_q;
  logic          gnt_id_q;
  logic          last_q;
  logic [CW-1:0] wait_q;

  logic [31:0]   mem_q [DEPTH];

  logic          req_s    [2];
  logic          cmpl_s   [2];
  logic          accept_s [2];
  logic          gnt_valid_s;
  logic          gnt_id_s;
  logic          done_s;
  logic [AW-1:0] widx_s;
  logic [3:0]    wmask_s;
  logic [31:0]   wdata_s;
  logic          wen_s;

  assign haddr_s[0]  = p0.haddr;
  assign hwrite_s[0] = p0.hwrite;
  assign hsize_s[0]  = p0.hsize;
  assign htrans_s[0] = p0.htrans;
  assign hwdata_s[0] = p0.hwdata;
  assign haddr_s[1]  = p1.haddr;
  assign hwrite_s[1] = p1.hwrite;
  assign hsize_s[1]  = p1.hsize;
  assign htrans_s[1] = p1.htrans;
  assign hwdata_s[1] = p1.hwdata;

  assign p0.hrdata = hrdata_s[0];
  assign p0.hready = hready_s[0];
  assign p0.hresp  = hresp_s[0];
  assign p1.hrdata = hrdata_s[1];
  assign p1.hready = hready_s[1];
  assign p1.hresp  = hresp_s[1];

  // An access is legal when it is in range, has a supported size and is
  // naturally aligned for that size.
  function automatic logic access_ok(input logic [31:0] a, input logic [2:0] sz);
    logic in_range;
    logic aligned;
    in_range = ({2'b00, a[31:2]} < DEPTH_W);
    case (sz)
      3'd0:    aligned = 1'b1;
      3'd1:    aligned = (a[0] == 1'b0);
      3'd2:    aligned = (a[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
    return in_range && aligned;
  endfunction

  // Byte lanes written by a legal access of the given size and offset.
  function automatic logic [3:0] lane_mask(input logic [1:0] a, input logic [2:0] sz);
    logic [3:0] m;
    case (sz)
      3'd0:    m = 4'b0001 << a;
      3'd1:    m = a[1] ? 4'b1100 : 4'b0011;
      3'd2:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Pick the port that owns the array this cycle and detect its completion.
  always_comb begin
    req_s[0] = (state_q[0] == ST_REQ);
    req_s[1] = (state_q[1] == ST_REQ);
    if (gnt_hold_q) begin
      gnt_valid_s = 1'b1;
      gnt_id_s    = gnt_id_q;
    end else if (req_s[0] && req_s[1]) begin
      gnt_valid_s = 1'b1;
      gnt_id_s    = (ARB_MODE == 1) ? ~last_q : 1'b1;
    end else if (req_s[1]) begin
      gnt_valid_s = 1'b1;
      gnt_id_s    = 1'b1;
    end else if (req_s[0]) begin
      gnt_valid_s = 1'b1;
      gnt_id_s    = 1'b0;
    end else begin
      gnt_valid_s = 1'b0;
      gnt_id_s    = 1'b0;
    end
    done_s = gnt_valid_s && (wait_q == WAIT_LAST);
  end

  // Per-port bus responses and address-phase acceptance.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      cmpl_s[p] = done_s && (gnt_id_s == 1'(p));
      case (state_q[p])
        ST_IDLE: begin hready_s[p] = 1'b1;      hresp_s[p] = 1'b0; end
        ST_REQ:  begin hready_s[p] = cmpl_s[p]; hresp_s[p] = 1'b0; end
        ST_ERR1: begin hready_s[p] = 1'b0;      hresp_s[p] = 1'b1; end
        ST_ERR2: begin hready_s[p] = 1'b1;      hresp_s[p] = 1'b1; end
        default: begin hready_s[p] = 1'b1;      hresp_s[p] = 1'b0; end
      endcase
      if (cmpl_s[p] && !write_q[p]) begin
        hrdata_s[p] = mem_q[addr_q[p][AW+1:2]];
      end else begin
        hrdata_s[p] = 32'h0000_0000;
      end
      accept_s[p] = hready_s[p] && (htrans_s[p] inside {2'b10, 2'b11});
    end
  end

  // Write port of the array, driven by whichever port completes a write.
  always_comb begin
    widx_s  = addr_q[gnt_id_s][AW+1:2];
    wmask_s = lane_mask(addr_q[gnt_id_s][1:0], size_q[gnt_id_s]);
    wdata_s = hwdata_s[gnt_id_s];
    wen_s   = done_s && write_q[gnt_id_s];
  end

  // Port FSMs, captured address phases, grant holding and wait counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        state_q[p] <= ST_IDLE;
        addr_q[p]  <= '0;
        write_q[p] <= 1'b0;
        size_q[p]  <= 3'd0;
      end
      gnt_hold_q <= 1'b0;
      gnt_id_q   <= 1'b0;
      last_q     <= 1'b1;
      wait_q     <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (accept_s[p]) begin
          addr_q[p]  <= haddr_s[p][AW+1:0];
          write_q[p] <= hwrite_s[p];
          size_q[p]  <= hsize_s[p];
          state_q[p] <= access_ok(haddr_s[p], hsize_s[p]) ? ST_REQ : ST_ERR1;
        end else if (state_q[p] == ST_ERR1) begin
          state_q[p] <= ST_ERR2;
        end else if (hready_s[p]) begin
          state_q[p] <= ST_IDLE;
        end else begin
          state_q[p] <= state_q[p];
        end
      end
      if (done_s) begin
        gnt_hold_q <= 1'b0;
        wait_q     <= '0;
        last_q     <= gnt_id_s;
      end else if (gnt_valid_s) begin
        gnt_hold_q <= 1'b1;
        gnt_id_q   <= gnt_id_s;
        wait_q     <= wait_q + 1'b1;
      end else begin
        gnt_hold_q <= gnt_hold_q;
        wait_q     <= wait_q;
      end
    end
  end

  // Byte-lane merge into the array; contents survive reset, but a write
  // completing in a reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (!reset && wen_s) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask_s[b]) begin
          mem_q[widx_s][8*b +: 8] <= wdata_s[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_vscale_hasti_dp_sram.sv
// Directed bench for the dual-port hasti SRAM. Three instances cover fixed
// priority, round robin and wait states. Stimulus sets bus inputs and the
// expected bus outputs for each cycle. One compare process checks every bus
// on the falling edge. A word-level reference memory supplies read data.
module tb_vscale_hasti_dp_sram;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Bus k = 2*instance + port.
  logic [31:0] t_addr  [6];
  logic        t_write [6];
  logic [2:0]  t_size  [6];
  logic [1:0]  t_trans [6];
  logic [31:0] t_wdata [6];
  logic [31:0] o_rdata [6];
  logic        o_rdy   [6];
  logic        o_resp  [6];

  logic        e_chk   [6];
  logic        e_rdy   [6];
  logic        e_resp  [6];
  logic [31:0] e_data  [6];

  logic [31:0] ref_mem [3][DEPTH];
  logic [31:0] err_addr [3];
  logic [2:0]  err_size [3];
  string       tag;
  int          n_checks = 0;
  int          n_errors = 0;

  vscale_hasti_dp_sram_if ifc [6] ();

  for (genvar g = 0; g < 6; g++) begin : g_bus
    assign ifc[g].haddr  = t_addr[g];
    assign ifc[g].hwrite = t_write[g];
    assign ifc[g].hsize  = t_size[g];
    assign ifc[g].htrans = t_trans[g];
    assign ifc[g].hwdata = t_wdata[g];
    assign o_rdata[g]    = ifc[g].hrdata;
    assign o_rdy[g]      = ifc[g].hready;
    assign o_resp[g]     = ifc[g].hresp;
  end

  vscale_hasti_dp_sram #(.DEPTH(DEPTH), .WAIT_STATES(0), .ARB_MODE(0)) dut_fp (
    .clk(clk), .reset(reset), .p0(ifc[0]), .p1(ifc[1]));
  vscale_hasti_dp_sram #(.DEPTH(DEPTH), .WAIT_STATES(0), .ARB_MODE(1)) dut_rr (
    .clk(clk), .reset(reset), .p0(ifc[2]), .p1(ifc[3]));
  vscale_hasti_dp_sram #(.DEPTH(DEPTH), .WAIT_STATES(2), .ARB_MODE(0)) dut_ws (
    .clk(clk), .reset(reset), .p0(ifc[4]), .p1(ifc[5]));

  // Reference byte merge: the lanes covered by a 2**sz-byte access, rounded
  // down to its natural boundary, take the write data.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [31:0] a, input logic [2:0] sz);
    int n;
    int first;
    logic [31:0] r;
    n     = 1 << sz;
    first = int'(a % 32'd4);
    first = first - (first % n);
    r     = old;
    for (int b = 0; b < 4; b++) begin
      if (b >= first && b < first + n) r[8*b +: 8] = wd[8*b +: 8];
    end
    return r;
  endfunction

  task automatic mw(input int d, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    ref_mem[d][a[7:2]] = merge(ref_mem[d][a[7:2]], wd, a, sz);
  endtask

  task automatic pin(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // Advance one cycle; every bus then defaults to idle inputs and an idle
  // expected response unless the test overrides it.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < 6; k++) begin
      t_trans[k] = 2'b00;
      e_chk[k]   = 1'b1;
      e_rdy[k]   = 1'b1;
      e_resp[k]  = 1'b0;
      e_data[k]  = 32'h0;
    end
  endtask

  task automatic addr_ph(input int k, input logic [31:0] a, input logic w, input logic [2:0] sz);
    t_addr[k]  = a;
    t_write[k] = w;
    t_size[k]  = sz;
    t_trans[k] = 2'b10;
  endtask

  task automatic expect_bus(input int k, input logic rdy, input logic resp, input logic [31:0] data);
    e_rdy[k]  = rdy;
    e_resp[k] = resp;
    e_data[k] = data;
  endtask

  // Compare every bus against its expectation, away from the rising edge.
  always @(negedge clk) begin
    for (int k = 0; k < 6; k++) begin
      if (e_chk[k]) begin
        n_checks++;
        if (o_rdy[k] !== e_rdy[k] || o_resp[k] !== e_resp[k] || o_rdata[k] !== e_data[k]) begin
          n_errors++;
          $display("FAIL %s bus%0d @%0t: got hready=%b hresp=%b hrdata=%h, want hready=%b hresp=%b hrdata=%h",
                   tag, k, $time, o_rdy[k], o_resp[k], o_rdata[k], e_rdy[k], e_resp[k], e_data[k]);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    tag   = "reset";
    for (int k = 0; k < 6; k++) begin
      t_addr[k] = 32'h0; t_write[k] = 1'b0; t_size[k] = 3'd0;
      t_trans[k] = 2'b00; t_wdata[k] = 32'h0;
      e_chk[k] = 1'b0; e_rdy[k] = 1'b1; e_resp[k] = 1'b0; e_data[k] = 32'h0;
    end
    err_addr[0] = 32'(4 * DEPTH); err_size[0] = 3'd2;
    err_addr[1] = 32'h1;          err_size[1] = 3'd1;
    err_addr[2] = 32'h10;         err_size[2] = 3'd3;
    tick();
    tick();
    reset = 1'b0;

    pin("merge_byte", merge(32'h11223344, 32'hAA000000, 32'h23, 3'd0), 32'hAA223344);
    pin("merge_half", merge(32'h11223344, 32'h55660000, 32'h22, 3'd1), 32'h55663344);

    // Port 0 word write then back-to-back read; then BUSY is not captured.
    tag = "t1_wr_rd";
    addr_ph(0, 32'h10, 1'b1, 3'd2);
    tick();
    t_wdata[0] = 32'hDEADBEEF; mw(0, 32'h10, 3'd2, 32'hDEADBEEF);
    addr_ph(0, 32'h10, 1'b0, 3'd2);
    tick();
    expect_bus(0, 1'b1, 1'b0, 32'hDEADBEEF);
    addr_ph(0, 32'h10, 1'b0, 3'd2); t_trans[0] = 2'b01;
    tick();
    tick();

    // Port 1 word, byte and half writes merged, then a full-word read.
    tag = "t2_lanes";
    addr_ph(1, 32'h20, 1'b1, 3'd2);
    tick();
    t_wdata[1] = 32'h11223344; mw(0, 32'h20, 3'd2, 32'h11223344);
    addr_ph(1, 32'h23, 1'b1, 3'd0);
    tick();
    t_wdata[1] = 32'hAA000000; mw(0, 32'h23, 3'd0, 32'hAA000000);
    addr_ph(1, 32'h20, 1'b1, 3'd1);
    tick();
    t_wdata[1] = 32'h00005566; mw(0, 32'h20, 3'd1, 32'h00005566);
    addr_ph(1, 32'h20, 1'b0, 3'd2);
    tick();
    expect_bus(1, 1'b1, 1'b0, 32'hAA225566);
    pin("t2_model", ref_mem[0][8], 32'hAA225566);
    tick();

    // Fixed priority: same-cycle reads, port 1 first, port 0 stretched.
    tag = "t3_fixed_prio";
    addr_ph(0, 32'h10, 1'b0, 3'd2);
    addr_ph(1, 32'h20, 1'b0, 3'd2);
    tick();
    expect_bus(1, 1'b1, 1'b0, ref_mem[0][8]);
    expect_bus(0, 1'b0, 1'b0, 32'h0);
    tick();
    expect_bus(0, 1'b1, 1'b0, ref_mem[0][4]);
    tick();

    // A port 1 write is visible to a port 0 read completing next cycle.
    tag = "t3_cross_port";
    addr_ph(1, 32'h30, 1'b1, 3'd2);
    tick();
    t_wdata[1] = 32'h0BADF00D; mw(0, 32'h30, 3'd2, 32'h0BADF00D);
    addr_ph(0, 32'h30, 1'b0, 3'd2);
    tick();
    expect_bus(0, 1'b1, 1'b0, ref_mem[0][12]);
    tick();

    // Round robin: preload through port 1, then both ports stream reads.
    tag = "t4_rr_preload";
    addr_ph(3, 32'h0, 1'b1, 3'd2);
    tick();
    t_wdata[3] = 32'hA0A0A0A0; mw(1, 32'h0, 3'd2, 32'hA0A0A0A0);
    addr_ph(3, 32'h4, 1'b1, 3'd2);
    tick();
    t_wdata[3] = 32'hB1B1B1B1; mw(1, 32'h4, 3'd2, 32'hB1B1B1B1);
    tick();
    tag = "t4_rr_stream";
    addr_ph(2, 32'h0, 1'b0, 3'd2);
    addr_ph(3, 32'h4, 1'b0, 3'd2);
    tick();
    for (int i = 1; i <= 10; i++) begin
      if (i <= 9) begin
        addr_ph(2, 32'h0, 1'b0, 3'd2);
        addr_ph(3, 32'h4, 1'b0, 3'd2);
      end
      if (i % 2 == 1) begin
        expect_bus(2, 1'b1, 1'b0, ref_mem[1][0]);
        expect_bus(3, 1'b0, 1'b0, 32'h0);
      end else begin
        expect_bus(2, 1'b0, 1'b0, 32'h0);
        expect_bus(3, 1'b1, 1'b0, ref_mem[1][1]);
      end
      tick();
    end
    expect_bus(2, 1'b1, 1'b0, ref_mem[1][0]);
    tick();

    // Two wait states: write, read, then reset during an in-flight write.
    tag = "t5_wait_wr";
    addr_ph(4, 32'h8, 1'b1, 3'd2);
    tick();
    t_wdata[4] = 32'h12345678;
    expect_bus(4, 1'b0, 1'b0, 32'h0);
    tick();
    expect_bus(4, 1'b0, 1'b0, 32'h0);
    tick();
    mw(2, 32'h8, 3'd2, 32'h12345678);
    tick();
    tag = "t5_wait_rd";
    addr_ph(4, 32'h8, 1'b0, 3'd2);
    tick();
    expect_bus(4, 1'b0, 1'b0, 32'h0);
    tick();
    expect_bus(4, 1'b0, 1'b0, 32'h0);
    tick();
    expect_bus(4, 1'b1, 1'b0, 32'h12345678);
    tick();
    tag = "t5_reset_mid_write";
    addr_ph(4, 32'h8, 1'b1, 3'd2);
    tick();
    t_wdata[4] = 32'hFFFFFFFF;
    reset = 1'b1;
    expect_bus(4, 1'b0, 1'b0, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    tag = "t5_after_reset_rd";
    addr_ph(4, 32'h8, 1'b0, 3'd2);
    tick();
    expect_bus(4, 1'b0, 1'b0, 32'h0);
    tick();
    expect_bus(4, 1'b0, 1'b0, 32'h0);
    tick();
    expect_bus(4, 1'b1, 1'b0, ref_mem[2][2]);
    tick();

    // Error responses on port 0 with a concurrent port 1 read.
    tag = "t6_preload";
    addr_ph(0, 32'h0, 1'b1, 3'd2);
    tick();
    t_wdata[0] = 32'h55AA55AA; mw(0, 32'h0, 3'd2, 32'h55AA55AA);
    tick();
    for (int i = 0; i < 3; i++) begin
      tag = $sformatf("t6_err%0d", i);
      addr_ph(0, err_addr[i], 1'b1, err_size[i]);
      addr_ph(1, 32'h20, 1'b0, 3'd2);
      tick();
      t_wdata[0] = 32'hFFFFFFFF;
      expect_bus(0, 1'b0, 1'b1, 32'h0);
      expect_bus(1, 1'b1, 1'b0, ref_mem[0][8]);
      tick();
      expect_bus(0, 1'b1, 1'b1, 32'h0);
      tick();
    end
    tag = "t6_array_unchanged";
    addr_ph(0, 32'h0, 1'b0, 3'd2);
    tick();
    expect_bus(0, 1'b1, 1'b0, ref_mem[0][0]);
    addr_ph(0, 32'h10, 1'b0, 3'd2);
    tick();
    expect_bus(0, 1'b1, 1'b0, ref_mem[0][4]);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/vscale_hasti_dp_sram.md
Name: vscale_hasti_dp_sram

Overview:
Unified instruction/data memory with two AHB-Lite (hasti) slave ports: port 0 for imem and port 1 for dmem. Both ports share one word-organised array. It replaces the pair of single-port hasti SRAMs in vscale_top. Depth, wait states and arbitration mode are parameters. Contention between the ports is resolved by stretching the losing port's data phase with hready low. Out-of-range, misaligned and bad-size accesses return a two-cycle AHB ERROR response. hburst, hmastlock and hprot are not ported.

Parameters:
DEPTH, 1024, array size in 32-bit words; power of two, at least 2
WAIT_STATES, 0, hready-low cycles inserted before every granted data-phase completion
ARB_MODE, 0, 0 = fixed priority (port 1 wins); 1 = round robin (the port served last loses the next tie)

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
p0_haddr  in  32  port 0 address
p0_hwrite  in  1  port 0 write (1) or read (0)
p0_hsize  in  3  port 0 size: 0 = byte, 1 = half, 2 = word
p0_htrans  in  2  port 0 transfer type; bit 1 set means NONSEQ or SEQ
p0_hwdata  in  32  port 0 write data, valid in the data phase
p0_hrdata  out  32  port 0 read data
p0_hready  out  1  port 0 transfer done / ready
p0_hresp  out  1  port 0 response: 0 = OKAY, 1 = ERROR
p1_*  same eight signals for port 1

Behaviour:
- Reset (synchronous): both ports go to IDLE. hready=1, hresp=0, hrdata=0. Wait counters=0. Round-robin pointer favours port 0. Array contents are retained, not cleared. An in-flight write is discarded.
- Address phase: accepted when htrans[1]=1 and the port's own hready=1. Captured into per-port registers: addr, write, size.
- Captured accesses that fail a check go to ERR1, never touch the array, and bypass arbitration. The checks are:
  - out of range: haddr[31:2] >= DEPTH
  - bad size: hsize > 2
  - misaligned: half with addr[0]=1, or word with addr[1:0]!=0
- All other captured accesses go to REQ.
- Per-port states:
  - IDLE: hready=1.
  - REQ: hready=0 until completion.
  - ERR1: hready=0, hresp=1.
  - ERR2: hready=1, hresp=1.
- Arbitration: one array access per cycle.
  - Among ports in REQ, one is granted and holds the grant until it completes.
  - The other port waits in REQ with hready=0.
  - Grant is evaluated only when no grant is held.
  - ARB_MODE=0: port 1 wins a tie. ARB_MODE=1: the port not served last wins; the pointer updates on each completion.
- Wait states: the granted port counts WAIT_STATES cycles with hready=0, then completes.
  - Completion cycle: hready=1, hresp=0.
  - Zero-wait, uncontended: completes in the cycle right after the address phase.
- Read: in the completion cycle, hrdata = array[addr] (combinational from the captured address). hrdata=0 in all other cycles.
- Write: at the edge ending the completion cycle, the byte lanes of hwdata selected by size/addr[1:0] are merged into array[addr]:
  - byte: lane addr[1:0]
  - half: lanes {addr[1],0} and {addr[1],1}
  - word: all four lanes
  - Reads always return the full word.
- Pipelining: in a completion or ERR2 cycle the same port may present its next address phase; it is captured. This gives back-to-back transfers, one per cycle when uncontended with WAIT_STATES=0.
- Same-cycle ordering: a write completing in cycle N is visible to any read completing in cycle N+1, on either port.
- htrans IDLE/BUSY during an accepting cycle: nothing is captured; the port returns to or stays in IDLE.
- Reset asserted mid-REQ or mid-ERR: the state is abandoned and the port ends in IDLE with no array write.

Test Plan:
1. Port 0, WAIT_STATES=0: write word 0xDEADBEEF to 0x10, then read 0x10 back to back. Required: hready=1 in every cycle; read completion shows hrdata=0xDEADBEEF.
2. Port 1: word write 0x11223344 to 0x20; byte write to 0x23 with hwdata 0xAA000000; half write to 0x20 with hwdata 0x00005566; then read 0x20. Required: hrdata=0xAA225566.
3. ARB_MODE=0, both ports issue reads in the same cycle T. Required:
   - port 1 hready=1 at T+1
   - port 0 hready=0 at T+1 and 1 at T+2
   - both return the correct data
4. ARB_MODE=1, both ports stream continuous reads for 10 cycles. Required: completions alternate, starting with port 0; each port completes every second cycle.
5. WAIT_STATES=2, single read from port 0 at cycle T. Required: hready=0 at T+1 and T+2; hready=1 with data at T+3. Then assert reset at T+1 of an in-flight write. Required: hready=1 on the next cycle and the array word is unchanged.
6. Error cases, each on its own: address 4*DEPTH; half at 0x1; hsize=3. Required for each:
   - hready=0, hresp=1 for one cycle
   - then hready=1, hresp=1
   - the other port's concurrent read is unaffected
   - the array is unchanged
